// File: rtl/ham_minmax_engine.sv
// Min/max pairwise Hamming distance engine: loads NUM_WORDS 16-bit operands from dm,
// compares every pair once, then writes the minimum and maximum distance back to dm.
module ham_minmax_engine #(
   parameter int unsigned NUM_WORDS = 32,
   parameter int unsigned AW        = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MIN_ADDR  = 64,
   parameter int unsigned MAX_ADDR  = 65
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wr_data,
   output logic [4:0]    min_dist,
   output logic [4:0]    max_dist,
   output logic [4:0]    min_a,
   output logic [4:0]    min_b,
   output logic [4:0]    max_a,
   output logic [4:0]    max_b
);

   localparam int unsigned IW = 5;
   localparam int unsigned DW = 5;
   localparam int unsigned NB = 2 * NUM_WORDS;
   localparam int unsigned BW = $clog2(NB);
   localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
   localparam logic [IW-1:0] LAST_J    = IW'(NUM_WORDS - 2);
   localparam logic [IW-1:0] LAST_K    = IW'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CMP, S_WMIN, S_WMAX, S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [BW-1:0] r_b;
   logic [IW-1:0] r_j;
   logic [IW-1:0] r_k;
   logic [15:0]   r_words [NUM_WORDS];

   logic [15:0]   w_diff;
   logic [DW-1:0] w_dist;
   logic [DW-1:0] w_min_nxt;
   logic          w_last_byte;
   logic          w_last_pair;
   logic          w_first_pair;
   logic          w_min_upd;
   logic          w_max_upd;
   logic          w_start;

   // Next-state logic plus the combinational distance of the current pair
   always_comb begin
      w_next       = r_state;
      w_last_byte  = (r_b == LAST_BYTE);
      w_last_pair  = (r_j == LAST_J) && (r_k == LAST_K);
      w_first_pair = (r_j == IW'(0)) && (r_k == IW'(1));
      w_diff       = r_words[r_j] ^ r_words[r_k];
      w_dist       = '0;
      for (int i = 0; i < 16; i++) begin
         w_dist = w_dist + DW'(w_diff[i]);
      end
      w_min_upd = (r_state == S_CMP) && (w_first_pair || (w_dist < min_dist));
      w_max_upd = (r_state == S_CMP) && (w_first_pair || (w_dist > max_dist));
      w_min_nxt = w_min_upd ? w_dist : min_dist;

      case (r_state)
         S_IDLE:  if (req) w_next = S_LOAD;
         S_LOAD:  if (w_last_byte) w_next = S_CMP;
         S_CMP:   if (w_last_pair) w_next = S_WMIN;
         S_WMIN:  w_next = S_WMAX;
         S_WMAX:  w_next = S_DONE;
         S_DONE:  if (req) w_next = S_LOAD;
         default: w_next = S_IDLE;
      endcase

      w_start = (w_next == S_LOAD) && (r_state != S_LOAD);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_b         <= '0;
         r_j         <= '0;
         r_k         <= '0;
         done        <= 1'b0;
         mem_addr    <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= '0;
         min_dist    <= '0;
         max_dist    <= '0;
         min_a       <= '0;
         min_b       <= '0;
         max_a       <= '0;
         max_b       <= '0;
      end else begin
         r_state   <= w_next;
         done      <= (w_next == S_DONE);
         mem_wr_en <= (w_next == S_WMIN) || (w_next == S_WMAX);

         // Address leads the byte counter so the combinational read lines up with capture
         case (w_next)
            S_LOAD:  mem_addr <= w_start ? AW'(BASE_ADDR)
                                         : AW'(BASE_ADDR) + AW'(r_b) + AW'(1);
            S_WMIN:  mem_addr <= AW'(MIN_ADDR);
            S_WMAX:  mem_addr <= AW'(MAX_ADDR);
            default: mem_addr <= '0;
         endcase

         case (w_next)
            S_WMIN:  mem_wr_data <= {3'b000, w_min_nxt};
            S_WMAX:  mem_wr_data <= {3'b000, max_dist};
            default: mem_wr_data <= '0;
         endcase

         if (w_start) begin
            r_b <= '0;
         end else if (r_state == S_LOAD) begin
            r_b <= r_b + BW'(1);
         end

         if (r_state == S_LOAD) begin
            r_j <= '0;
            r_k <= IW'(1);
         end else if ((r_state == S_CMP) && !w_last_pair) begin
            if (r_k == LAST_K) begin
               r_j <= r_j + IW'(1);
               r_k <= r_j + IW'(2);
            end else begin
               r_k <= r_k + IW'(1);
            end
         end

         if (w_min_upd) begin
            min_dist <= w_dist;
            min_a    <= r_j;
            min_b    <= r_k;
         end
         if (w_max_upd) begin
            max_dist <= w_dist;
            max_a    <= r_j;
            max_b    <= r_k;
         end
      end
   end

   // Operand cache survives reset; bytes land big-endian within each word
   always_ff @(posedge clk) begin
      if (r_state == S_LOAD) begin
         if (!r_b[0]) begin
            r_words[r_b[BW-1:1]][15:8] <= mem_rd_data;
         end else begin
            r_words[r_b[BW-1:1]][7:0]  <= mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_ham_minmax_engine.sv
// Bench for ham_minmax_engine: dm model, brute-force pairwise distance model and
// a per-cycle compare process on done/write-strobe outputs.
module tb_ham_minmax_engine;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       req   = 1'b0;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
   logic [4:0] min_dist, max_dist, min_a, min_b, max_a, max_b;

   logic [7:0] dm [256];
   logic [7:0] res_min, res_max;
   int         wr_count = 0;

   int checks = 0;
   int errors = 0;
   int exp_min, exp_max, exp_mina, exp_minb, exp_maxa, exp_maxb;
   bit chk_en = 1'b0;

   ham_minmax_engine dut (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .min_dist(min_dist), .max_dist(max_dist),
      .min_a(min_a), .min_b(min_b), .max_a(max_a), .max_b(max_b)
   );

   always #5 clk = ~clk;

   assign mem_rd_data = dm[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en) begin
         if (mem_addr == 8'd64) res_min <= mem_wr_data;
         else if (mem_addr == 8'd65) res_max <= mem_wr_data;
         wr_count <= wr_count + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Brute force over all pairs; strict compare keeps the earliest pair on ties
   task automatic compute_model();
      logic [15:0] w [32];
      int d;
      for (int i = 0; i < 32; i++) w[i] = {dm[2*i], dm[2*i+1]};
      exp_min = 99; exp_max = -1;
      for (int j = 0; j < 32; j++) begin
         for (int k = j + 1; k < 32; k++) begin
            d = $countones(w[j] ^ w[k]);
            if (d < exp_min) begin exp_min = d; exp_mina = j; exp_minb = k; end
            if (d > exp_max) begin exp_max = d; exp_maxa = j; exp_maxb = k; end
         end
      end
   endtask

   // Results must be stable and correct on every cycle done is high and on every write
   always @(negedge clk) begin
      if (chk_en && reset) begin
         if (done) begin
            check("min_dist", min_dist, exp_min);
            check("max_dist", max_dist, exp_max);
            check("min_a", min_a, exp_mina);
            check("min_b", min_b, exp_minb);
            check("max_a", max_a, exp_maxa);
            check("max_b", max_b, exp_maxb);
         end
         if (mem_wr_en) begin
            check("wr_addr_legal", int'(mem_addr == 8'd64 || mem_addr == 8'd65), 1);
            check("wr_data", mem_wr_data, (mem_addr == 8'd64) ? exp_min : exp_max);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // mode 0: single req pulse; 1: random req toggling until WMIN; 2: req held high
   task automatic run(input int mode, output int cyc);
      @(negedge clk);
      req = 1'b1;
      cyc = 0;
      while (cyc < 2000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done) break;
         if (mode == 0) req = 1'b0;
         else if (mode == 1) req = (cyc <= 561) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (mode != 2) req = 1'b0;
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic finish_run(input string name, input int cyc, input int base_wr);
      check({name, "_latency"}, cyc, 563);
      check({name, "_wr_pulses"}, wr_count - base_wr, 2);
      check({name, "_dm64"}, res_min, exp_min);
      check({name, "_dm65"}, res_max, exp_max);
      repeat (3) @(negedge clk);
      check({name, "_done_held"}, done, 1);
      check({name, "_no_extra_wr"}, wr_count - base_wr, 2);
   endtask

   task automatic fill_t3();
      for (int i = 0; i < 32; i++) begin
         dm[2*i]   = 8'(i);
         dm[2*i+1] = 8'(i);
      end
   endtask

   initial begin
      int cyc, cyc2, base;
      for (int i = 0; i < 256; i++) dm[i] = 8'h00;

      do_reset();
      check("rst_done", done, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wr_data", mem_wr_data, 0);
      check("rst_min", min_dist, 0);
      check("rst_max", max_dist, 0);
      check("rst_idx", {min_a, min_b, max_a, max_b}, 0);

      // T1: all zero
      compute_model();
      check("t1_model_min", exp_min, 0);
      check("t1_model_max", exp_max, 0);
      check("t1_model_maxb", exp_maxb, 1);
      chk_en = 1'b1;
      base = wr_count;
      run(0, cyc);
      finish_run("t1", cyc, base);

      // T2: word 5 all ones
      do_reset();
      dm[10] = 8'hFF; dm[11] = 8'hFF;
      compute_model();
      check("t2_model_max", exp_max, 16);
      check("t2_model_maxa", exp_maxa, 0);
      check("t2_model_maxb", exp_maxb, 5);
      check("t2_model_minb", exp_minb, 1);
      base = wr_count;
      run(0, cyc);
      finish_run("t2", cyc, base);

      // T3: word i = i*0x0101
      do_reset();
      fill_t3();
      compute_model();
      check("t3_model_min", exp_min, 2);
      check("t3_model_max", exp_max, 10);
      check("t3_model_maxb", exp_maxb, 31);
      base = wr_count;
      run(0, cyc);
      finish_run("t3", cyc, base);

      // T4: reset during CMP, then clean rerun
      do_reset();
      base = wr_count;
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (299) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("t4_done", done, 0);
      check("t4_wr_en", mem_wr_en, 0);
      check("t4_min", min_dist, 0);
      check("t4_addr", mem_addr, 0);
      check("t4_no_wr", wr_count - base, 0);
      @(negedge clk);
      reset = 1'b1;
      base = wr_count;
      run(0, cyc);
      finish_run("t4", cyc, base);

      // T5: req held through DONE restarts immediately
      do_reset();
      base = wr_count;
      run(2, cyc);
      check("t5_latency1", cyc, 563);
      @(posedge clk);
      #1;
      check("t5_done_one_cycle", done, 0);
      cyc2 = 1;
      while (cyc2 < 2000) begin
         @(posedge clk);
         cyc2++;
         #1;
         if (done) break;
      end
      req = 1'b0;
      check("t5_latency2", cyc2, 563);
      check("t5_wr_pulses", wr_count - base, 4);
      check("t5_dm64", res_min, exp_min);
      check("t5_dm65", res_max, exp_max);
      repeat (3) @(negedge clk);
      check("t5_done_held", done, 1);

      // T6 and extra: random operands, req chatter during LOAD/CMP
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < 64; i++) dm[i] = 8'($urandom);
         if (r == 3) for (int i = 0; i < 64; i++) dm[i] = dm[i] & 8'($urandom);
         compute_model();
         base = wr_count;
         run((r == 1) ? 0 : 1, cyc);
         finish_run("t6_rand", cyc, base);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
